// File: rtl/mdu_ctrl.sv
// MULT/DIV unit with funct decode, owns HI/LO; multiply busy MUL_LAT cycles, divide busy WIDTH cycles.
// Backpressure: any MDU funct presented while busy raises stall and is held until the cycle after busy falls.
module mdu_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [5:0]       ft,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             IsMdu,
  output logic [WIDTH-1:0] rdata,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam int CMAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CW   = $clog2(CMAX);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa, opb, rem;
  logic             msgn, qneg, rneg, dz;
  logic             dec, sdiv;

  always_comb begin
    dec = 1'b0;
    case (ft)
      F_MFHI, F_MTHI, F_MFLO, F_MTLO,
      F_MULT, F_MULTU, F_DIV, F_DIVU: dec = 1'b1;
      default:                        dec = 1'b0;
    endcase
  end

  assign IsMdu = en & dec;
  assign busy  = (state != S_IDLE);
  assign stall = IsMdu & busy;
  assign sdiv  = (ft == F_DIV);

  always_comb begin
    rdata = '0;
    case (ft)
      F_MFHI:  rdata = hi;
      F_MFLO:  rdata = lo;
      default: rdata = '0;
    endcase
  end

  // One extra sign bit per operand lets one signed multiplier serve MULT and MULTU.
  logic signed [WIDTH:0]     ma, mb;
  logic signed [2*WIDTH-1:0] prod;
  assign ma   = $signed({msgn & opa[WIDTH-1], opa});
  assign mb   = $signed({msgn & opb[WIDTH-1], opb});
  assign prod = (2*WIDTH)'(ma) * (2*WIDTH)'(mb);

  // Restoring step: opa shifts the dividend out MSB-first and the quotient in LSB-first.
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rem_nx, quo_nx, quo_fix, rem_fix;
  assign trial   = {rem, opa[WIDTH-1]};
  assign ge      = (trial >= {1'b0, opb});
  assign rem_nx  = ge ? (trial[WIDTH-1:0] - opb) : trial[WIDTH-1:0];
  assign quo_nx  = {opa[WIDTH-2:0], ge};
  assign quo_fix = qneg ? -quo_nx : quo_nx;
  assign rem_fix = rneg ? -rem_nx : rem_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      rem   <= '0;
      msgn  <= 1'b0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      dz    <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            case (ft)
              F_MTHI: hi <= a;
              F_MTLO: lo <= a;
              F_MULT, F_MULTU: begin
                opa   <= a;
                opb   <= b;
                msgn  <= (ft == F_MULT);
                cnt   <= CW'(MUL_LAT - 1);
                state <= S_MUL;
              end
              F_DIV, F_DIVU: begin
                opa   <= (sdiv && a[WIDTH-1]) ? -a : a;
                opb   <= (sdiv && b[WIDTH-1]) ? -b : b;
                rem   <= '0;
                qneg  <= sdiv && (a[WIDTH-1] ^ b[WIDTH-1]);
                rneg  <= sdiv && a[WIDTH-1];
                dz    <= (b == '0);
                cnt   <= CW'(WIDTH - 1);
                state <= S_DIV;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            {hi, lo} <= prod;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DIV: begin
          opa <= quo_nx;
          rem <= rem_nx;
          if (cnt == '0) begin
            // With a zero divisor the remainder path already reproduces the dividend.
            lo    <= dz ? '1 : quo_fix;
            hi    <= rem_fix;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: driver pushes reference results, a negedge monitor pops and compares.
module tb_mdu_ctrl;
  localparam int W  = 32;
  localparam int ML = 4;

  logic         clk = 1'b0;
  logic         rst, en;
  logic [5:0]   ft;
  logic [W-1:0] a, b, rdata, hi, lo;
  logic         IsMdu, stall, busy;

  always #5 clk = ~clk;

  mdu_ctrl #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .en(en), .ft(ft), .a(a), .b(b),
    .IsMdu(IsMdu), .rdata(rdata), .stall(stall), .busy(busy), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    int          lat;
  } res_t;

  res_t        res_q[$];
  logic [31:0] mf_q[$];
  logic [31:0] m_hi, m_lo;
  int          nvec = 0;
  int          nerr = 0;
  bit          mon_on = 1'b0;
  logic [5:0]  ftab [0:10] = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19,
                               6'h1A, 6'h1B, 6'h20, 6'h21, 6'h00};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_mdu_f(input logic [5:0] f);
    return (f inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: decoupled from the driver, compares whatever the DUT presents.
  initial begin : monitor
    int   bcnt  = 0;
    logic pbusy = 1'b0;
    logic prst  = 1'b0;
    res_t r;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk("ismdu", 64'(IsMdu), 64'(en && is_mdu_f(ft)));
        if (rst || prst) begin
          bcnt = 0;
        end else begin
          if (busy) bcnt++;
          if (pbusy && !busy) begin
            if (res_q.size() == 0) begin
              nvec++; nerr++;
              $display("FAIL commit_unexpected: got hi=%h lo=%h required no commit", hi, lo);
            end else begin
              r = res_q.pop_front();
              chk("commit_hi", 64'(hi), 64'(r.h));
              chk("commit_lo", 64'(lo), 64'(r.l));
              chk("busy_len", 64'(bcnt), 64'(r.lat));
            end
            bcnt = 0;
          end
          if (en && !stall && (ft == 6'h10 || ft == 6'h12)) begin
            if (mf_q.size() == 0) begin
              nvec++; nerr++;
              $display("FAIL mf_unexpected: got rdata=%h required no move-from", rdata);
            end else begin
              chk("mf_rdata", 64'(rdata), 64'(mf_q.pop_front()));
            end
          end
        end
        pbusy = busy;
        prst  = rst;
      end
    end
  end

  // Issue one MDU instruction, holding it while stalled. Entered and left at posedge+1.
  task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                       output int stalls);
    res_t        r;
    longint      sx, sy, q, rm;
    logic [63:0] u;
    bit          done;
    en = 1'b1; ft = f; a = x; b = y;
    sx = $signed(x);
    sy = $signed(y);
    case (f)
      6'h10: mf_q.push_back(m_hi);
      6'h12: mf_q.push_back(m_lo);
      6'h11: m_hi = x;
      6'h13: m_lo = x;
      6'h18: begin u = 64'(sx * sy); {m_hi, m_lo} = u; end
      6'h19: begin u = {32'b0, x} * {32'b0, y}; {m_hi, m_lo} = u; end
      6'h1A: begin
        if (y == 0) begin
          m_lo = 32'hFFFFFFFF; m_hi = x;
        end else begin
          q = sx / sy; rm = sx % sy;
          m_lo = q[31:0]; m_hi = rm[31:0];
        end
      end
      6'h1B: begin
        if (y == 0) begin
          m_lo = 32'hFFFFFFFF; m_hi = x;
        end else begin
          m_lo = x / y; m_hi = x % y;
        end
      end
      default: ;
    endcase
    if (f inside {6'h18, 6'h19}) begin
      r.h = m_hi; r.l = m_lo; r.lat = ML; res_q.push_back(r);
    end else if (f inside {6'h1A, 6'h1B}) begin
      r.h = m_hi; r.l = m_lo; r.lat = W; res_q.push_back(r);
    end
    stalls = 0;
    done   = 1'b0;
    while (!done && stalls < 300) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
      else stalls++;
    end
    if (!done) begin
      nvec++; nerr++;
      $display("FAIL stall_timeout: got stall=1 for %0d cycles required release", stalls);
    end
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic nonmdu(input logic [5:0] f);
    en = 1'b1; ft = f; a = $urandom; b = $urandom;
    @(negedge clk);
    chk("nonmdu_stall", 64'(stall), 64'(0));
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", 64'(busy), 64'(0));
  endtask

  initial begin : driver
    int          s;
    logic [31:0] old_lo;
    logic [5:0]  f;
    rst = 1'b1; en = 1'b0; ft = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; mon_on = 1'b1;
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));
    @(posedge clk); #1;
    nonmdu(6'h20);

    issue(6'h18, 32'hFFFFFFFD, 32'd5, s); wait_idle();
    chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo), 64'hFFFFFFF1);
    issue(6'h19, 32'hFFFFFFFF, 32'd2, s); wait_idle();
    chk("multu_hi", 64'(hi), 64'h1);
    chk("multu_lo", 64'(lo), 64'hFFFFFFFE);
    issue(6'h1A, 32'hFFFFFFF9, 32'd2, s); wait_idle();
    chk("div_lo", 64'(lo), 64'hFFFFFFFD);
    chk("div_hi", 64'(hi), 64'hFFFFFFFF);
    issue(6'h1B, 32'd7, 32'd0, s); wait_idle();
    chk("divu0_lo", 64'(lo), 64'hFFFFFFFF);
    chk("divu0_hi", 64'(hi), 64'h7);
    issue(6'h1A, 32'h80000000, 32'hFFFFFFFF, s); wait_idle();
    chk("divovf_lo", 64'(lo), 64'h80000000);
    chk("divovf_hi", 64'(hi), 64'h0);
    issue(6'h1A, 32'hFFFFFFF9, 32'd0, s); wait_idle();
    chk("div0_lo", 64'(lo), 64'hFFFFFFFF);
    chk("div0_hi", 64'(hi), 64'hFFFFFFF9);

    // Move-from held behind a divide, issued one cycle into the operation.
    issue(6'h1B, 32'd100, 32'd7, s);
    nonmdu(6'h21);
    issue(6'h12, 32'd0, 32'd0, s);
    chk("mflo_stall_cycles", 64'(s), 64'd31);

    issue(6'h11, 32'h12345678, 32'd0, s);
    issue(6'h10, 32'd0, 32'd0, s);
    chk("mfhi_no_stall", 64'(s), 64'd0);

    // Move-to during a multiply must wait for the commit.
    issue(6'h18, 32'd3, 32'd4, s);
    old_lo = lo;
    en = 1'b1; ft = 6'h13; a = 32'h000055AA;
    @(negedge clk);
    chk("mtlo_stall", 64'(stall), 64'd1);
    chk("mtlo_lo_hold", 64'(lo), 64'(old_lo));
    issue(6'h13, 32'h000055AA, 32'd0, s);
    chk("mtlo_after", 64'(lo), 64'h55AA);
    issue(6'h12, 32'd0, 32'd0, s);

    // Back-to-back: multiply queued behind a divide.
    issue(6'h1A, 32'd1234567, 32'hFFFFFFF0, s);
    issue(6'h18, 32'hFFFF0000, 32'h00010001, s);
    chk("b2b_stall_cycles", 64'(s), 64'(W));
    wait_idle();

    // Reset mid-divide aborts without committing.
    issue(6'h1A, 32'd1000, 32'd3, s);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    res_q.delete();
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    rst = 1'b0;
    issue(6'h18, 32'd6, 32'd7, s); wait_idle();
    chk("post_rst_lo", 64'(lo), 64'd42);
    chk("post_rst_hi", 64'(hi), 64'd0);

    for (int i = 0; i < 80; i++) begin
      f = ftab[$urandom_range(0, 10)];
      if (is_mdu_f(f)) issue(f, rand_op(), rand_op(), s);
      else nonmdu(f);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    for (int i = 0; i < 200 && (busy || res_q.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("queues_drained", 64'(res_q.size() + mf_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit with integrated R-type funct decoder; sits in EX beside the ALU and owns the HI/LO registers.
- Decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO funct codes.
- Runs multi-cycle multiply (fixed latency) and iterative divide (one quotient bit per cycle).
- Raises a pipeline stall when an MDU instruction arrives while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be >= 4.
- MUL_LAT, 4, cycles busy for MULT/MULTU; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  R-type instruction valid in EX; ft/a/b are meaningful only when en=1
- ft  input  6  funct field
- a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
- b  input  WIDTH  rt operand (divisor / multiplier)
- IsMdu  output  1  combinational; en=1 and ft is one of the 8 MDU functs
- rdata  output  WIDTH  combinational; HI when ft=0x10, LO when ft=0x12, else 0
- stall  output  1  combinational; IsMdu & busy
- busy  output  1  registered; operation in flight
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Funct map:
  - 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU
  - All other functs: IsMdu=0, no effect.
- Reset (rst=1 at an edge): state=IDLE, busy=0, hi=0, lo=0, counter=0, operand/partial registers=0. Applies mid-operation too: the operation is aborted and no result is committed.
- States: IDLE, MUL, DIV. busy=1 exactly when state != IDLE.
- Accept rule: in IDLE with en=1.
  - MULT/MULTU: capture a, b and signedness; go to MUL; counter=MUL_LAT-1.
  - DIV/DIVU: capture |a|, |b| (signed) or a, b (unsigned), plus the sign of the quotient and of the remainder; go to DIV; counter=WIDTH-1.
  - MTHI/MTLO: hi<=a or lo<=a at that edge; stay IDLE.
  - MFHI/MFLO: rdata valid in the same cycle; no state change.
- While busy, every MDU instruction is refused and stall=1. The pipeline holds the instruction, and it is accepted in the first cycle after busy falls. Non-MDU instructions proceed normally (stall=0).
- MUL: counter decrements each cycle. At the edge where counter==0, commit the 2*WIDTH product {hi,lo} of the captured operands (signed or unsigned) and return to IDLE. busy is high for exactly MUL_LAT cycles.
- DIV: restoring division, one quotient bit per cycle, MSB first. At the edge where counter==0, commit and return to IDLE; busy is high for exactly WIDTH cycles.
  - Signed fixup at commit: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - lo = quotient, hi = remainder.
- Divide by zero (captured b==0): lo = all ones, hi = a (the original dividend, as supplied), for both DIV and DIVU. Latency unchanged.
- Signed overflow (a=MIN, b=-1): lo=MIN, hi=0.
- hi/lo change only on commit, MTHI/MTLO, or reset. They hold during busy, so MFHI/MFLO read stale-free values only because stall blocks them.
- Back-to-back: a new MULT/DIV may be accepted in the cycle immediately after the commit edge (busy=0 that cycle).

Test Plan:
- Reset, then idle: hi=0, lo=0, busy=0, stall=0. IsMdu=0 for ft=0x20 with en=1.
- MULT a=0xFFFFFFFD (-3), b=5 -> busy for 4 cycles -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU a=0xFFFFFFFF, b=2 -> hi=0x1, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy for 32 cycles -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x7.
- MFLO issued the cycle after a DIV is accepted -> stall=1 for 31 cycles. On the first cycle with busy=0, stall=0 and rdata equals the new lo.
- MTHI a=0x12345678 then MFHI -> rdata=0x12345678 on the next cycle. A MTLO issued during MUL -> stall=1 and lo unchanged until commit.
- Assert rst for one cycle at DIV cycle 10 -> busy=0, hi=lo=0 next cycle. A subsequent MULT 6*7 -> lo=42, hi=0.
